// File: rtl/mdu_iter_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// EX-side aliases and the op decode used at accept.
package mdu_iter_pkg;

    localparam logic [2:0] MDU_MULT  = 3'b000;
    localparam logic [2:0] MDU_MULTU = 3'b001;
    localparam logic [2:0] MDU_MADD  = 3'b010;
    localparam logic [2:0] MDU_MADDU = 3'b011;
    localparam logic [2:0] MDU_MSUB  = 3'b100;
    localparam logic [2:0] MDU_MSUBU = 3'b101;
    localparam logic [2:0] MDU_DIV   = 3'b110;
    localparam logic [2:0] MDU_DIVU  = 3'b111;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_FIXUP = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // The existing EX decode still tests these names against valid_o.
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    typedef struct packed {
        logic is_div;
        logic is_acc;
        logic is_sub;
        logic is_signed;
    } mdu_dec_t;

    function automatic mdu_dec_t mdu_decode(input logic [2:0] op);
        mdu_dec_t d;
        d.is_div    = (op[2:1] == 2'b11);
        d.is_acc    = (op[2:1] == 2'b01);
        d.is_sub    = (op[2:1] == 2'b10);
        d.is_signed = ~op[0];
        return d;
    endfunction

endpackage

// File: rtl/mdu_iter_core_step.sv
// One iteration of the MDU datapath: shift-add multiply step or restoring
// divide step on the {hi, lo} working pair.
module mdu_core_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;
    logic           fits;

    always_comb begin
        // Multiply: lo holds the remaining multiplier bits, hi the running high half.
        sum    = hi_i + (lo_i[0] ? {1'b0, m_i} : '0);
        // Divide: lo holds the dividend being shifted out and quotient shifted in.
        rem_sh = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
        diff   = rem_sh - {1'b0, m_i};
        fits   = (rem_sh >= {1'b0, m_i});
        if (div_i) begin
            hi_o = fits ? diff : rem_sh;
            lo_o = {lo_i[WIDTH-2:0], fits};
        end else begin
            hi_o = {1'b0, sum[WIDTH:1]};
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide engine for EX: one start/valid handshake covering
// mul, multiply-accumulate and divide, one result bit per CALC cycle.
//
// state  | meaning
// IDLE   | waiting for start_i; ready_o high
// CALC   | WIDTH iterations of shift-add or restoring subtract
// FIXUP  | sign correction, accumulate; result_o loaded
// DONE   | valid_o strobe; ready_o high so a new op may be accepted
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic [2:0]           op_i,
    input  logic [WIDTH-1:0]     opa_i,
    input  logic [WIDTH-1:0]     opb_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic                 cancel_i,
    output logic                 ready_o,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 dz_o
);

    logic [1:0]         state_r;
    logic [CNT_W-1:0]   cnt_r;
    mdu_dec_t           dec_r;
    logic               sa_r;
    logic               sb_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   m_r;
    logic [WIDTH:0]     hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [2*WIDTH-1:0] result_r;
    logic               dz_r;

    mdu_dec_t           dec_in;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               accept;
    logic               div_zero;

    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic [2*WIDTH-1:0] fix_res;

    always_comb begin
        dec_in   = mdu_decode(op_i);
        mag_a    = (dec_in.is_signed && opa_i[WIDTH-1]) ? -opa_i : opa_i;
        mag_b    = (dec_in.is_signed && opb_i[WIDTH-1]) ? -opb_i : opb_i;
        // Cancel wins over start even in IDLE/DONE, so it also blocks an accept.
        accept   = (state_r == ST_IDLE || state_r == ST_DONE) && start_i && !cancel_i;
        div_zero = dec_in.is_div && (opb_i == '0);
    end

    mdu_core_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_i (dec_r.is_div),
        .hi_i  (hi_r),
        .lo_i  (lo_r),
        .m_i   (m_r),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    // sa_r/sb_r are only set for signed ops, so unsigned ops pass through unchanged.
    always_comb begin
        prod   = {hi_r[WIDTH-1:0], lo_r};
        prod_s = (sa_r ^ sb_r) ? -prod : prod;
        quo_s  = (sa_r ^ sb_r) ? -lo_r : lo_r;
        rem_s  = sa_r ? -hi_r[WIDTH-1:0] : hi_r[WIDTH-1:0];
        if (dec_r.is_div) begin
            fix_res = {rem_s, quo_s};
        end else if (dec_r.is_acc) begin
            fix_res = acc_r + prod_s;
        end else if (dec_r.is_sub) begin
            fix_res = acc_r - prod_s;
        end else begin
            fix_res = prod_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= '0;
            dec_r    <= '0;
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            acc_r    <= '0;
            m_r      <= '0;
            hi_r     <= '0;
            lo_r     <= '0;
            result_r <= '0;
            dz_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        dec_r <= dec_in;
                        sa_r  <= dec_in.is_signed & opa_i[WIDTH-1];
                        sb_r  <= dec_in.is_signed & opb_i[WIDTH-1];
                        acc_r <= acc_i;
                        hi_r  <= '0;
                        cnt_r <= CNT_W'(WIDTH - 1);
                        if (dec_in.is_div) begin
                            lo_r <= mag_a;
                            m_r  <= mag_b;
                        end else begin
                            lo_r <= mag_b;
                            m_r  <= mag_a;
                        end
                        if (div_zero) begin
                            state_r  <= ST_DONE;
                            result_r <= {opa_i, {WIDTH{1'b1}}};
                            dz_r     <= 1'b1;
                        end else begin
                            state_r <= ST_CALC;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (cancel_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        hi_r <= step_hi;
                        lo_r <= step_lo;
                        if (cnt_r == '0) begin
                            state_r <= ST_FIXUP;
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                end
                ST_FIXUP: begin
                    if (cancel_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        result_r <= fix_res;
                        dz_r     <= 1'b0;
                        state_r  <= ST_DONE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign ready_o  = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign busy_o   = (state_r == ST_CALC) || (state_r == ST_FIXUP);
    assign valid_o  = (state_r == ST_DONE) ? DivResultReady : DivResultNotReady;
    assign result_o = result_r;
    assign dz_o     = dz_r & valid_o;

endmodule
